// File: rtl/trace_pkg.sv
// Shared types for the trace monitor: FSM states, record layout and widths.
package trace_pkg;

  localparam int CW_DEF = 32;
  localparam int PC_W   = 32;
  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [CW_DEF-1:0] cycle;
    logic [PC_W-1:0]   pc;
    logic [CW_DEF-1:0] stall;
    logic [CW_DEF-1:0] flush;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // Same field order as trace_rec_t, for counter widths other than CW_DEF.
  function automatic int rec_width(input int cw);
    return 3 * cw + PC_W;
  endfunction

endpackage

// File: rtl/trace_monitor_if.sv
// Record stream from the trace monitor to a host/logger (valid/ready).
interface trace_monitor_if import trace_pkg::*; #(parameter int CW = CW_DEF);

  logic            valid;
  logic            ready;
  logic [CW-1:0]   cycle;
  logic [PC_W-1:0] pc;
  logic [CW-1:0]   stall;
  logic [CW-1:0]   flush;

  modport master (output valid, cycle, pc, stall, flush, input ready);
  modport slave  (input valid, cycle, pc, stall, flush, output ready);

endinterface

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO succeeds when a pop
// happens on the same edge.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/trace_monitor.sv
// Per-cycle CPU trace recorder: samples PC/stall/flush while running, buffers
// records and drains them to a host. TRACE_BACKPRESSURE_EN freezes the CPU instead of dropping.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | sampling one record per enabled cycle
// DRAIN | budget reached, emptying the FIFO
// DONE  | all records delivered, held until reset
module trace_monitor import trace_pkg::*; #(
  parameter int DEPTH      = 4,
  parameter int MAX_CYCLES = 64,
  parameter int CW         = CW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              hazard_stall_i,
  input  logic              is_branch_i,
  input  logic              flush_i,
  trace_monitor_if.master   trace,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              cpu_hold_o,
  output logic              done_o
);

  localparam int RW = (CW == CW_DEF) ? REC_W : rec_width(CW);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cycle_q, cycle_d;
  logic [CW-1:0]     stall_q, stall_d;
  logic [CW-1:0]     flush_q, flush_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              done_q, done_d;

  logic          fifo_full, fifo_empty, pop, sample, hold;
  logic [RW-1:0] wdata, rdata;

`ifdef TRACE_BACKPRESSURE_EN
  assign hold = fifo_full & (state_q == RUN);
`else
  assign hold = 1'b0;
`endif

  assign sample = (state_q == RUN) & start_i & ~hold;
  assign pop    = ~fifo_empty & trace.ready;
  // Record carries the counts including the sampled cycle itself.
  assign wdata  = {cycle_q, pc_i, stall_d, flush_d};

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    stall_d = stall_q;
    flush_d = flush_q;
    drop_d  = drop_q;
    if (sample) begin
      stall_d = stall_q + CW'(hazard_stall_i & ~is_branch_i);
      flush_d = flush_q + CW'(flush_i);
      cycle_d = cycle_q + CW'(1);
      if (fifo_full && !pop && drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (sample && cycle_q == LAST_CYCLE) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    done_d = done_q | (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (sample),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign trace.valid = ~fifo_empty;
  assign trace.cycle = rdata[RW-1 -: CW];
  assign trace.pc    = rdata[2*CW +: PC_W];
  assign trace.stall = rdata[CW +: CW];
  assign trace.flush = rdata[0 +: CW];

  assign drop_cnt_o = drop_q;
  assign cpu_hold_o = hold;
  assign done_o     = done_q;

endmodule

// File: tb/tb_trace_monitor.sv
// Scoreboard bench for trace_monitor: directed runs push expected records,
// a negedge monitor pops and compares every accepted record.
module tb_trace_monitor;
  import trace_pkg::*;

  localparam int CW    = 32;
  localparam int DEPTH = 4;
  localparam int MAXC  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hazard, branch, flush;
  logic [31:0] pc;
  logic [15:0] drop_cnt;
  logic        cpu_hold, done;

  int checks   = 0;
  int failures = 0;

  trace_rec_t exp_q[$];

  trace_monitor_if #(.CW(CW)) tif();

  trace_monitor #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC), .CW(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .pc_i           (pc),
    .hazard_stall_i (hazard),
    .is_branch_i    (branch),
    .flush_i        (flush),
    .trace          (tif),
    .drop_cnt_o     (drop_cnt),
    .cpu_hold_o     (cpu_hold),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: compare accepted records and hold-stability of a stalled head.
  logic       stall_pend = 1'b0;
  trace_rec_t held_rec;
  always @(negedge clk) begin
    trace_rec_t cur, e;
    if (!rst && tif.valid) begin
      cur = {tif.cycle, tif.pc, tif.stall, tif.flush};
      if (stall_pend) chk("stable_while_stalled", cur, held_rec);
      if (tif.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_record got=%0h exp=none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("record", cur, e);
        end
        stall_pend = 1'b0;
      end else begin
        stall_pend = 1'b1;
        held_rec   = cur;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  // Hand-derived per-test stimulus and expectations.
  function automatic logic stall_at(input int t, input int c);
    return (t == 2) && (c == 5 || c == 9 || c == 12);
  endfunction
  function automatic logic branch_at(input int t, input int c);
    return (t == 2) && (c == 12);
  endfunction
  function automatic logic flush_at(input int t, input int c);
    return (t == 2) && (c == 3 || c == 4 || c == 20);
  endfunction
  function automatic logic [31:0] exp_stall(input int t, input int c);
    return (t == 2) ? 32'((c >= 5) + (c >= 9)) : 32'd0;
  endfunction
  function automatic logic [31:0] exp_flush(input int t, input int c);
    return (t == 2) ? 32'((c >= 3) + (c >= 4) + (c >= 20)) : 32'd0;
  endfunction
  function automatic logic dropped(input int t, input int c);
`ifdef TRACE_BACKPRESSURE_EN
    return 1'b0;
`else
    return (t == 4) && (c >= 4) && (c <= 9);
`endif
  endfunction
  function automatic logic ready_at(input int t, input int w);
    if (t == 4) return w >= 10;
    if (t == 5) return w < 28;
    return 1'b1;
  endfunction
  function automatic logic hold_exp(input int t, input int w);
`ifdef TRACE_BACKPRESSURE_EN
    return (t == 4) && (w >= 4) && (w <= 10);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; hazard = 1'b0; branch = 1'b0; flush = 1'b0; pc = '0;
    tif.ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs one test; stops after stop_at recorded cycles (or the full budget).
  task automatic run_test(input int t, input int stop_at);
    int c, w;
    logic paused, took;
    trace_rec_t r;
    start = 1'b1;
    @(posedge clk);
    #1;
    c = 0;
    w = 0;
    while (c < MAXC && c < stop_at && w < 400) begin
      paused    = (t == 2) && (w >= 31) && (w <= 33);
      tif.ready = ready_at(t, w);
      start     = ~paused;
      pc        = 32'h1000 + 32'(c * 4);
      hazard    = paused ? 1'b1 : stall_at(t, c);
      branch    = paused ? 1'b0 : branch_at(t, c);
      flush     = paused ? 1'b1 : flush_at(t, c);
      if (t == 4) chk("cpu_hold", cpu_hold, hold_exp(t, w));
      took = !paused && !cpu_hold;
      if (took && !dropped(t, c)) begin
        r.cycle = 32'(c);
        r.pc    = pc;
        r.stall = exp_stall(t, c);
        r.flush = exp_flush(t, c);
        exp_q.push_back(r);
      end
      @(posedge clk);
      #1;
      if (took) c++;
      w++;
    end
    if (w >= 400) begin
      checks++;
      failures++;
      $display("FAIL run_budget got=%0d exp=%0d", c, MAXC);
    end
    hazard = 1'b0; branch = 1'b0; flush = 1'b0;
  endtask

  task automatic finish_test(input int t);
    int g;
    tif.ready = 1'b1;
    g = 0;
    while (!done && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("done", done, 1'b1);
    chk("queue_empty", exp_q.size(), 0);
    chk("valid_at_done", tif.valid, 1'b0);
`ifdef TRACE_BACKPRESSURE_EN
    chk("drop_cnt", drop_cnt, 16'd0);
`else
    chk("drop_cnt", drop_cnt, (t == 4) ? 16'd6 : 16'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("done_sticky", done, 1'b1);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", tif.valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_data", {tif.cycle, tif.pc, tif.stall, tif.flush}, 128'd0);

    run_test(1, MAXC);
    finish_test(1);

    do_reset();
    run_test(2, MAXC);
    finish_test(2);

    do_reset();
    run_test(4, MAXC);
    finish_test(4);

    do_reset();
    run_test(5, 30);
    chk("midrun_buffered", exp_q.size(), 3);
    chk("midrun_valid", tif.valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", tif.valid, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_drop", drop_cnt, 16'd0);
    chk("midrst_data", {tif.cycle, tif.pc, tif.stall, tif.flush}, 128'd0);
    do_reset();
    run_test(1, MAXC);
    finish_test(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
